// File: rtl/pc_dec_7_3.sv
// Count-to-word expander: each accepted 3-bit count becomes a 7-bit word with that many ones,
// queued in a DEPTH-entry FIFO; out_total accumulates popcounts of popped words (mod 256).
// Optional build macro PC_DEC_ROTATE_EN rotates the ones pattern by a per-accept pointer.
module pc_dec_7_3 #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_count,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_d,
    output logic [7:0] out_total
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    function automatic logic [2:0] popcnt7(input logic [6:0] w);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 7; i++) s = s + 3'(w[i]);
        return s;
    endfunction

    logic [DEPTH-1:0][6:0] mem_q;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           occ_q, occ_d;
    logic [7:0]            total_q, total_d;
    logic [6:0]            therm_w, wr_word, head_w;
    logic                  accept, pop;

    // Handshake depends only on registered occupancy, so a pop never opens a slot the same cycle.
    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head_w    = mem_q[rd_ptr_q];
    assign out_d     = out_valid ? head_w : 7'd0;
    assign out_total = total_q;

    always_comb therm_w = 7'h7f >> (3'd7 - in_count);

`ifdef PC_DEC_ROTATE_EN
    logic [2:0]  rot_q, rot_d;
    logic [13:0] dbl_w;

    // Left rotation within 7 bits: take the upper half of the doubled word after shifting.
    always_comb begin
        dbl_w   = {therm_w, therm_w} << rot_q;
        wr_word = dbl_w[13:7];
        rot_d   = rot_q;
        if (accept) rot_d = (rot_q == 3'd6) ? 3'd0 : rot_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) rot_q <= 3'd0;
        else     rot_q <= rot_d;
    end
`else
    always_comb wr_word = therm_w;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        total_d  = total_q;
        if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            total_d  = total_q + {5'd0, popcnt7(head_w)};
        end
        case ({accept, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            total_q  <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            total_q  <= total_d;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= wr_word;
    end

endmodule

// File: doc/pc_dec_7_3.md
PC_DEC_7_3 -- requirements
Module: pc_dec_7_3

Interface
REQ-001 Parameter DEPTH, default 2, output FIFO entries; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer offers in_count.
REQ-005 in_ready  output  1  block can accept a count this cycle.
REQ-006 in_count  input  3  requested number of ones, 0..7.
REQ-007 out_valid  output  1  out_d holds a valid word.
REQ-008 out_ready  input  1  consumer takes out_d this cycle.
REQ-009 out_d  output  7  generated word with popcount equal to the accepted in_count.
REQ-010 out_total  output  8  running sum of popcounts of all words popped, modulo 256.

Function
REQ-011 Input accept SHALL occur on a cycle with in_valid && in_ready; output pop SHALL occur on a cycle with out_valid && out_ready.
REQ-012 in_ready SHALL equal (occupancy < DEPTH), depending only on registered state, never on out_ready.
REQ-013 out_valid SHALL equal (occupancy > 0).
REQ-014 Each accepted count SHALL expand to a 7-bit thermometer word: bits [in_count-1:0] = 1, others 0; count 0 -> 7'b0000000, count 7 -> 7'b1111111.
REQ-015 The expanded word SHALL be written into the FIFO on the accept edge; latency accept -> out_valid SHALL be exactly 1 cycle when the FIFO was empty; no same-cycle passthrough.
REQ-016 Words SHALL leave in acceptance order; out_d SHALL show the head entry and SHALL hold stable while out_valid && !out_ready.
REQ-017 Simultaneous accept and pop SHALL leave occupancy unchanged and both operations SHALL take effect.
REQ-018 Full: in_ready = 0; in_valid ignored, even when a pop occurs the same cycle.
REQ-019 Empty: out_valid = 0; out_ready ignored; out_d value unspecified but out_total unchanged.
REQ-020 FIFO read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 On each pop, out_total SHALL increase by the popcount of the popped word, wrapping modulo 256 (e.g. 254 + 7 -> 5).
REQ-022 in_count values SHALL never be rejected; all eight codes are legal.

Reset
REQ-023 While rst is high at a clock edge: occupancy, pointers, out_total and rotation pointer SHALL clear to 0.
REQ-024 During and immediately after reset: in_ready = 1, out_valid = 0, out_total = 0, out_d = 7'b0000000.
REQ-025 Reset mid-operation SHALL discard all queued words without popping them; out_total SHALL not count them.
REQ-026 An accept coinciding with a reset edge SHALL be discarded.

Configuration
REQ-027 Macro PC_DEC_ROTATE_EN SHALL control ones placement.
REQ-028 With PC_DEC_ROTATE_EN defined: a 3-bit rotation pointer (0..6) SHALL left-rotate the thermometer word circularly within 7 bits before FIFO write, then advance by 1 per accept, wrapping 6 -> 0.
REQ-029 Without PC_DEC_ROTATE_EN: no rotation pointer exists; words SHALL be pure thermometer per REQ-014.
REQ-030 Popcount, ordering, handshake and out_total behaviour SHALL be identical in both builds.

Verification
REQ-031 Reset, then in_count=3 with in_valid one cycle, out_ready=1 -> out_valid high next cycle, out_d=7'b0000111, out_total=3 the cycle after the pop.
REQ-032 out_ready=0, push 5 then 7 then 1 (DEPTH=2) -> in_ready low after second accept, third held; release out_ready -> out_d 7'b0011111, 7'b1111111, 7'b0000001 in order, out_total=13.
REQ-033 Full FIFO, in_valid=1 and out_ready=1 same cycle -> one pop, no accept; in_ready rises next cycle.
REQ-034 Continuous in_valid/out_ready, 37 words of count 7 -> out_total wraps: 259 mod 256 = 3.
REQ-035 PC_DEC_ROTATE_EN defined, eight accepts of count 2 -> out_d sequence 0000011, 0000110, 0001100, 0011000, 0110000, 1100000, 1000001, 0000011.
REQ-036 Two words queued, assert rst one cycle -> out_valid=0, out_total=0, in_ready=1; next accept count 4 yields 7'b0001111 (rotation restarted at 0 when enabled).
